// File: rtl/pcs_receive_if.sv
// Code-group side and GMII receive side of the 1000BASE-X PCS receive block.
// The decoder drives the master modport; pcs_receive uses the slave modport.
interface pcs_receive_if;
    logic       sync_status;
    logic       rx_even;
    logic [7:0] rx_data;
    logic       rx_is_k;
    logic       rx_invalid;
    logic       receiving;
    logic       RX_DV;
    logic       RX_ER;
    logic [7:0] RXD;

    modport master (
        output sync_status, rx_even, rx_data, rx_is_k, rx_invalid,
        input  receiving, RX_DV, RX_ER, RXD
    );

    modport slave (
        input  sync_status, rx_even, rx_data, rx_is_k, rx_invalid,
        output receiving, RX_DV, RX_ER, RXD
    );
endinterface

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive state machine: decoded code-groups in, registered GMII Rx out.
// Define PCS_RX_STATS_EN to add saturating frame_cnt/err_cnt statistics ports.
module pcs_receive #(
    parameter int unsigned MAX_LEN = 1530,
    parameter int unsigned LEN_W   = 12,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              CLOCK,
    input  logic              mr_main_reset,
    pcs_receive_if.slave      rx_if
`ifdef PCS_RX_STATS_EN
    ,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] err_cnt
`endif
);

    typedef enum logic [2:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        FALSE_CARRIER,
        RECEIVE,
        END_T,
        END_R
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_receiving;
    logic               r_dv;
    logic               r_er;
    logic [7:0]         r_rxd;
    logic [LEN_W-1:0]   r_len;

    logic               w_receiving;
    logic               w_dv;
    logic               w_er;
    logic [7:0]         w_rxd;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W-1:0]   w_len_inc;

    logic               w_is_d;
    logic               w_is_kv;
    logic               w_comma;
    logic               w_comma_even;
    logic               w_s;
    logic               w_t;
    logic               w_r;
    logic               w_jabber;

    assign w_is_d       = !rx_if.rx_is_k && !rx_if.rx_invalid;
    assign w_is_kv      =  rx_if.rx_is_k && !rx_if.rx_invalid;
    assign w_comma      = w_is_kv && (rx_if.rx_data == 8'hBC);
    assign w_comma_even = w_comma && rx_if.rx_even;
    assign w_s          = w_is_kv && (rx_if.rx_data == 8'hFB);
    assign w_t          = w_is_kv && (rx_if.rx_data == 8'hFD);
    assign w_r          = w_is_kv && (rx_if.rx_data == 8'hF7);
    assign w_jabber     = (r_len >= LEN_W'(MAX_LEN));
    assign w_len_inc    = (r_len == '1) ? r_len : r_len + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_receiving = 1'b0;
        w_dv        = 1'b0;
        w_er        = 1'b0;
        w_rxd       = '0;
        w_len       = '0;
        if (!rx_if.sync_status) begin
            // Losing sync while carrier is up is reported as a one-cycle error.
            w_state_nxt = LINK_FAILED;
            w_er        = r_receiving;
        end else begin
            case (r_state)
                LINK_FAILED: w_state_nxt = WAIT_FOR_K;
                WAIT_FOR_K: begin
                    if (w_comma_even) w_state_nxt = RX_K;
                end
                RX_K: w_state_nxt = w_is_d ? IDLE_D : WAIT_FOR_K;
                IDLE_D: begin
                    if (w_comma_even) begin
                        w_state_nxt = RX_K;
                    end else if (w_s) begin
                        w_state_nxt = RECEIVE;
                        w_receiving = 1'b1;
                        w_dv        = 1'b1;
                        w_rxd       = 8'h55;
                        w_len       = LEN_W'(1);
                    end else if (!w_is_d) begin
                        w_state_nxt = FALSE_CARRIER;
                        w_receiving = 1'b1;
                        w_er        = 1'b1;
                        w_rxd       = 8'h0E;
                    end
                end
                FALSE_CARRIER: begin
                    if (w_comma_even) begin
                        w_state_nxt = RX_K;
                    end else begin
                        w_receiving = 1'b1;
                        w_er        = 1'b1;
                        w_rxd       = 8'h0E;
                    end
                end
                RECEIVE: begin
                    // T and early-end comma outrank jabber, which outranks data errors.
                    if (w_t) begin
                        w_state_nxt = END_T;
                        w_receiving = 1'b1;
                    end else if (w_comma) begin
                        w_state_nxt = RX_K;
                        w_er        = 1'b1;
                    end else if (w_jabber) begin
                        w_state_nxt = WAIT_FOR_K;
                        w_er        = 1'b1;
                    end else begin
                        w_receiving = 1'b1;
                        w_dv        = 1'b1;
                        w_er        = !w_is_d;
                        w_rxd       = rx_if.rx_data;
                        w_len       = w_len_inc;
                    end
                end
                END_T: begin
                    if (w_r) begin
                        w_state_nxt = END_R;
                        w_receiving = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_FOR_K;
                        w_er        = 1'b1;
                    end
                end
                END_R: begin
                    if (w_comma_even) begin
                        w_state_nxt = RX_K;
                    end else if (w_r) begin
                        w_receiving = 1'b1;
                        w_er        = 1'b1;
                        w_rxd       = 8'h0F;
                    end else begin
                        w_state_nxt = WAIT_FOR_K;
                    end
                end
                default: w_state_nxt = LINK_FAILED;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state     <= LINK_FAILED;
            r_receiving <= 1'b0;
            r_dv        <= 1'b0;
            r_er        <= 1'b0;
            r_rxd       <= '0;
            r_len       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_receiving <= w_receiving;
            r_dv        <= w_dv;
            r_er        <= w_er;
            r_rxd       <= w_rxd;
            r_len       <= w_len;
        end
    end

    assign rx_if.receiving = r_receiving;
    assign rx_if.RX_DV     = r_dv;
    assign rx_if.RX_ER     = r_er;
    assign rx_if.RXD       = r_rxd;

`ifdef PCS_RX_STATS_EN
    logic [STAT_W-1:0] r_frame_cnt;
    logic [STAT_W-1:0] r_err_cnt;
    logic              w_frame_done;
    logic              w_er_rise;

    assign w_frame_done = (r_state == END_R) && (w_state_nxt == RX_K);
    assign w_er_rise    = w_er && !r_er;

    always_ff @(posedge CLOCK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_frame_done && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_er_rise && (r_err_cnt != '1))      r_err_cnt   <= r_err_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_pcs_receive.sv
// Directed testbench for pcs_receive: idle, frames, errors, false carrier, jabber, sync loss, reset.
module tb_pcs_receive;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   dv_cnt;
    int   jab_dv;
    int   jab_er;
    int   jab_idx;
    logic jab_recv;

    pcs_receive_if u_if();

`ifdef PCS_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`endif

    pcs_receive #(
        .MAX_LEN (1530),
        .LEN_W   (12),
        .STAT_W  (16)
    ) u_dut (
        .CLOCK         (clk),
        .mr_main_reset (rst_n),
        .rx_if         (u_if)
`ifdef PCS_RX_STATS_EN
        ,
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic recv, input logic dv,
                           input logic er, input logic [7:0] rxd);
        chk({tag, ".receiving"}, 32'(u_if.receiving), 32'(recv));
        chk({tag, ".RX_DV"},     32'(u_if.RX_DV),     32'(dv));
        chk({tag, ".RX_ER"},     32'(u_if.RX_ER),     32'(er));
        chk({tag, ".RXD"},       32'(u_if.RXD),       32'(rxd));
    endtask

    task automatic cg(input logic k, input logic inv, input logic [7:0] d, input logic ev);
        u_if.rx_is_k    = k;
        u_if.rx_invalid = inv;
        u_if.rx_data    = d;
        u_if.rx_even    = ev;
        @(posedge clk);
        #1;
    endtask

    task automatic cg_d(input logic [7:0] d);  cg(1'b0, 1'b0, d, 1'b0);     endtask
    task automatic cg_comma();                 cg(1'b1, 1'b0, 8'hBC, 1'b1); endtask
    task automatic cg_comma_odd();             cg(1'b1, 1'b0, 8'hBC, 1'b0); endtask
    task automatic cg_s();                     cg(1'b1, 1'b0, 8'hFB, 1'b0); endtask
    task automatic cg_t();                     cg(1'b1, 1'b0, 8'hFD, 1'b1); endtask
    task automatic cg_r();                     cg(1'b1, 1'b0, 8'hF7, 1'b0); endtask
    task automatic cg_inv(input logic [7:0] d); cg(1'b0, 1'b1, d, 1'b0);    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        u_if.sync_status = 1'b0;
        u_if.rx_even     = 1'b0;
        u_if.rx_data     = 8'h00;
        u_if.rx_is_k     = 1'b0;
        u_if.rx_invalid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef PCS_RX_STATS_EN
        chk("reset.frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset.err_cnt",   32'(err_cnt),   32'd0);
`endif

        // Link up and reach IDLE_D
        rst_n = 1'b1;
        u_if.sync_status = 1'b1;
        cg_d(8'h00);
        cg_comma();     chk_out("rxk", 1'b0, 1'b0, 1'b0, 8'h00);
        cg_d(8'h50);
        cg_comma();
        cg_d(8'h50);    chk_out("idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Frame 1: preamble, SFD, 64 data bytes
        dv_cnt = 0;
        cg_s();         chk_out("f1.sop", 1'b1, 1'b1, 1'b0, 8'h55);
        if (u_if.RX_DV) dv_cnt++;
        for (int i = 0; i < 6; i++) begin
            cg_d(8'h55);
            if (u_if.RX_DV) dv_cnt++;
        end
        cg_d(8'hD5);    chk_out("f1.sfd", 1'b1, 1'b1, 1'b0, 8'hD5);
        if (u_if.RX_DV) dv_cnt++;
        for (int i = 1; i <= 64; i++) begin
            cg_d(8'(i));
            chk("f1.data", 32'(u_if.RXD), 32'(i));
            if (u_if.RX_DV) dv_cnt++;
        end
        cg_t();         chk_out("f1.T", 1'b1, 1'b0, 1'b0, 8'h00);
        chk("f1.dv_cycles", 32'(dv_cnt), 32'd72);
        cg_r();         chk_out("f1.R", 1'b1, 1'b0, 1'b0, 8'h00);
        cg_comma();     chk_out("f1.end", 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef PCS_RX_STATS_EN
        chk("f1.frame_cnt", 32'(frame_cnt), 32'd1);
`endif
        cg_d(8'h50);

        // Frame 2: INV as 10th code-group, then carrier extension
        cg_s();
        for (int i = 0; i < 8; i++) cg_d(8'(8'h10 + i));
        cg_inv(8'hAA);  chk_out("f2.inv", 1'b1, 1'b1, 1'b1, 8'hAA);
        cg_d(8'h77);    chk_out("f2.after", 1'b1, 1'b1, 1'b0, 8'h77);
        cg_t();
        cg_r();         chk_out("f2.R1", 1'b1, 1'b0, 1'b0, 8'h00);
        cg_r();         chk_out("f2.ext", 1'b1, 1'b0, 1'b1, 8'h0F);
        cg_comma();     chk_out("f2.end", 1'b0, 1'b0, 1'b0, 8'h00);
        cg_d(8'h50);

        // False carrier
        cg_inv(8'h00);  chk_out("fc.start", 1'b1, 1'b0, 1'b1, 8'h0E);
        cg_d(8'h12);    chk_out("fc.hold", 1'b1, 1'b0, 1'b1, 8'h0E);
        cg_comma_odd(); chk_out("fc.odd", 1'b1, 1'b0, 1'b1, 8'h0E);
        cg_comma();     chk_out("fc.end", 1'b0, 1'b0, 1'b0, 8'h00);
        cg_d(8'h50);

        // Early end by comma
        cg_s();
        repeat (3) cg_d(8'h99);
        cg_comma();     chk_out("early", 1'b0, 1'b0, 1'b1, 8'h00);
        cg_d(8'h50);    chk_out("early.idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // T not followed by R
        cg_s();
        cg_d(8'h01);
        cg_t();
        cg_d(8'h02);    chk_out("badT", 1'b0, 1'b0, 1'b1, 8'h00);
        cg_comma();
        cg_d(8'h50);

        // Jabber: S + 1600 D
        jab_dv = 0; jab_er = 0; jab_idx = 0; jab_recv = 1'b1;
        cg_s();
        if (u_if.RX_DV) jab_dv++;
        for (int i = 1; i <= 1600; i++) begin
            cg_d(8'(i));
            if (u_if.RX_DV) jab_dv++;
            if (u_if.RX_ER) begin
                jab_er++;
                if (jab_idx == 0) begin
                    jab_idx  = i;
                    jab_recv = u_if.receiving;
                end
            end
        end
        chk("jab.dv_cycles", 32'(jab_dv), 32'd1530);
        chk("jab.er_index",  32'(jab_idx), 32'd1530);
        chk("jab.er_pulses", 32'(jab_er), 32'd1);
        chk("jab.recv_at_er", 32'(jab_recv), 32'd0);
        cg_s();         chk_out("jab.noS", 1'b0, 1'b0, 1'b0, 8'h00);
        cg_comma();
        cg_d(8'h50);

        // T exactly at the length limit wins over jabber
        cg_s();
        for (int i = 1; i <= 1529; i++) cg_d(8'h3C);
        chk_out("lim.last", 1'b1, 1'b1, 1'b0, 8'h3C);
        cg_t();         chk_out("lim.T", 1'b1, 1'b0, 1'b0, 8'h00);
        cg_r();
        cg_comma();     chk_out("lim.end", 1'b0, 1'b0, 1'b0, 8'h00);
        cg_d(8'h50);

        // Sync loss mid-frame
        cg_s();
        cg_d(8'h11);
        u_if.sync_status = 1'b0;
        cg_d(8'h22);    chk_out("sync.loss", 1'b0, 1'b0, 1'b1, 8'h00);
        cg_d(8'h22);    chk_out("sync.down", 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef PCS_RX_STATS_EN
        chk("stats.frame_cnt", 32'(frame_cnt), 32'd3);
        chk("stats.err_cnt",   32'(err_cnt),   32'd7);
`endif

        // Async reset mid-frame
        u_if.sync_status = 1'b1;
        cg_d(8'h00);
        cg_comma();
        cg_d(8'h50);
        cg_s();
        cg_d(8'h33);    chk_out("pre_rst", 1'b1, 1'b1, 1'b0, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef PCS_RX_STATS_EN
        chk("async_rst.frame_cnt", 32'(frame_cnt), 32'd0);
        chk("async_rst.err_cnt",   32'(err_cnt),   32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
